// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs request-to-send, shifts the frame out on device clock falls, checks ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t          state;
  logic [1:0]      clk_s;
  logic [1:0]      dat_s;
  logic            clk_d;
  logic            clk_fall;
  logic            clk_sync;
  logic            dat_sync;
  logic [8:0]      frame;
  logic [3:0]      idx;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   tcnt;
  logic            timeout_hit;

  // idle bus level is high, so the synchronizers reset to 1
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_dat_in};
      clk_d <= clk_s[1];
    end
  end

  assign clk_sync    = clk_s[1];
  assign dat_sync    = dat_s[1];
  assign clk_fall    = clk_d & ~clk_s[1];
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // error and done are issued on the transition back to idle,
  // so tx_ready rises in the same cycle as the pulse
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      frame      <= '0;
      idx        <= '0;
      inh_cnt    <= '0;
      tcnt       <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx_valid) begin
            frame      <= {~^tx_data, tx_data};
            inh_cnt    <= IW'(INHIBIT_CYCLES - 1);
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt - IW'(1);
          if (inh_cnt <= IW'(1)) begin
            ps2_dat_oe <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          ps2_clk_oe <= 1'b0;
          idx        <= '0;
          tcnt       <= '0;
          state      <= S_SEND;
        end
        default: begin
          if (timeout_hit) begin
            tx_error   <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (state == S_SEND && clk_fall) begin
              if (idx == 4'd9) begin
                ps2_dat_oe <= 1'b0;
                state      <= S_ACK;
              end else begin
                ps2_dat_oe <= ~frame[0];
                frame      <= frame >> 1;
                idx        <= idx + 4'd1;
              end
            end else if (state == S_ACK && clk_fall) begin
              if (!dat_sync) begin
                state <= S_WAITIDLE;
              end else begin
                tx_error   <= 1'b1;
                tx_ready   <= 1'b1;
                busy       <= 1'b0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                state      <= S_IDLE;
              end
            end else if (state == S_WAITIDLE && clk_sync && dat_sync) begin
              tx_done    <= 1'b1;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
